// File: rtl/kgp_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encoding, byte order and the default image-size limit.
package kgp_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  // First byte of a word lands in bits [7:0].
  localparam bit BYTE_ORDER_LE = 1'b1;

  localparam int DEFAULT_MAX_WORDS = 1024;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Packs accepted bytes into 32-bit words, one byte per cycle.
// word_valid pulses for one cycle the cycle after the 4th byte.
module byte_packer
  import kgp_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sh;

  assign last_byte = (cnt == 2'd3);

  // Shift bytes in and emit the completed word with a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 2'd0;
      sh         <= 24'd0;
      word_valid <= 1'b0;
      word       <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 2'd1;
        if (last_byte) begin
          word_valid <= 1'b1;
          word <= BYTE_ORDER_LE ? {in_data, sh}
                                : {sh, in_data};
        end else begin
          sh <= BYTE_ORDER_LE ? {in_data, sh[23:8]}
                              : {sh[15:0], in_data};
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory.
// Trailing XOR checksum when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
  import kgp_loader_pkg::*;
#(
  parameter int MAX_WORDS  = DEFAULT_MAX_WORDS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_wren,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] left;
  logic [15:0] idx;
  logic [15:0] n;
  logic        acc;
  logic        pk_valid;
  logic        last_byte;
  logic        word_valid;
  logic [31:0] word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign acc      = rx_valid && rx_ready;
  assign n        = {rx_data, len_lo};
  assign pk_valid = acc && (state == DATA);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (pk_valid),
    .in_data    (rx_data),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  assign imem_wren  = word_valid;
  assign imem_wdata = word;
  assign imem_addr  = ADDR_WIDTH'({14'd0, idx, 2'b00});
  assign cpu_rst    = !done;

  // Load FSM; the final word's write strobe precedes done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LEN_LO;
      rx_ready <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      len_lo   <= 8'd0;
      left     <= 16'd0;
      idx      <= 16'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      if (word_valid) idx <= idx + 16'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (acc && state != CHECK) csum <= csum ^ rx_data;
`endif
      unique case (state)
        LEN_LO: begin
          if (acc) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (acc) begin
            if ({1'b0, n} > MAXW) begin
              state    <= ERROR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (n == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= DONE;
              done     <= 1'b1;
              rx_ready <= 1'b0;
`endif
            end else begin
              state <= DATA;
              left  <= n;
            end
          end
        end
        DATA: begin
          if (acc && last_byte) begin
            left <= left - 16'd1;
            if (left == 16'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state    <= CHECK;
`else
              state    <= DONE;
              rx_ready <= 1'b0;
`endif
            end
          end
        end
        CHECK: begin
          if (acc) begin
            rx_ready <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (rx_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
`else
            state <= ERROR;
            error <= 1'b1;
`endif
          end
        end
        DONE: begin
          done     <= 1'b1;
          rx_ready <= 1'b0;
        end
        ERROR: begin
          error    <= 1'b1;
          rx_ready <= 1'b0;
        end
        default: begin
          state    <= ERROR;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
// Checksum steps run when PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_wren;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;
  logic [63:0] sb[$];
  logic [7:0]  acc_x;

  program_loader #(.MAX_WORDS(1024), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_wren  (imem_wren),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard check of every write strobe.
  always @(negedge clk) begin
    if (imem_wren === 1'b1) begin
      logic [63:0] e;
      wcnt++;
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_wdata, e[31:0]);
      end
      chk("wr_cpu_rst", 32'(cpu_rst), 32'd1);
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rdy_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    acc_x    = acc_x ^ b;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_word(input int wi,
                           input logic [31:0] w,
                           input int gmax);
    sb.push_back({32'(wi * 4), w});
    for (int i = 0; i < 4; i++) begin
      gap($urandom_range(0, gmax));
      send(w[8*i +: 8]);
    end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    #1;
    chk("rst_cpu_rst_async", 32'(cpu_rst), 32'd1);
    @(negedge clk);
    chk("rst_wren", 32'(imem_wren), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst   = 1'b0;
    acc_x = 8'h00;
    sb.delete();
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd1);
  endtask

  // Close an image and check the done timing.
  task automatic end_image(input string tag);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = acc_x;
    send(c);
`else
    chk({tag, "_last_wren"}, 32'(imem_wren), 32'd1);
    chk({tag, "_done_early"}, 32'(done), 32'd0);
    @(negedge clk);
`endif
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    acc_x    = 8'h00;
    @(negedge clk);
    do_reset();

    // Two-word image, back to back.
    w0 = wcnt;
    send(8'h02);
    send(8'h00);
    send_word(0, 32'h0000_0013, 0);
    send_word(1, 32'h0302_0133, 0);
    end_image("img2");
    chk("img2_wcnt", 32'(wcnt - w0), 32'd2);

    // Bytes offered after done are ignored.
    w0       = wcnt;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    gap(6);
    chk("post_ready", 32'(rx_ready), 32'd0);
    chk("post_done", 32'(done), 32'd1);
    chk("post_wcnt", 32'(wcnt - w0), 32'd0);
    rx_valid = 1'b0;

    // Oversized image is rejected right after LEN_HI.
    do_reset();
    w0 = wcnt;
    send(8'h01);
    send(8'h04);
    chk("big_error", 32'(error), 32'd1);
    chk("big_ready", 32'(rx_ready), 32'd0);
    chk("big_cpu_rst", 32'(cpu_rst), 32'd1);
    gap(3);
    chk("big_wcnt", 32'(wcnt - w0), 32'd0);
    chk("big_done", 32'(done), 32'd0);

    // Four words with random valid gaps.
    do_reset();
    w0 = wcnt;
    send(8'h04);
    gap(2);
    send(8'h00);
    send_word(0, 32'hDEAD_BEEF, 3);
    send_word(1, 32'h0000_0093, 3);
    send_word(2, 32'h1234_5678, 3);
    send_word(3, 32'hA5A5_5A5A, 3);
    end_image("gap4");
    chk("gap4_wcnt", 32'(wcnt - w0), 32'd4);

    // Reset after 6 payload bytes, then a full reload.
    do_reset();
    send(8'h02);
    send(8'h00);
    send_word(0, 32'h4433_2211, 0);
    send(8'h55);
    send(8'h66);
    chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
    do_reset();
    w0 = wcnt;
    send(8'h02);
    send(8'h00);
    send_word(0, 32'h0000_0013, 0);
    send_word(1, 32'h0302_0133, 0);
    end_image("reload");
    chk("reload_wcnt", 32'(wcnt - w0), 32'd2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Good checksum.
    do_reset();
    send(8'h01);
    send(8'h00);
    send_word(0, 32'hDDCC_BBAA, 0);
    chk("cs_model", 32'(acc_x), 32'h01);
    send(8'h01);
    chk("cs_done", 32'(done), 32'd1);
    chk("cs_ok_err", 32'(error), 32'd0);

    // Bad checksum.
    do_reset();
    send(8'h01);
    send(8'h00);
    send_word(0, 32'hDDCC_BBAA, 0);
    send(8'h00);
    chk("csbad_error", 32'(error), 32'd1);
    chk("csbad_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("csbad_done", 32'(done), 32'd0);
    chk("csbad_ready", 32'(rx_ready), 32'd0);
`endif

    gap(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
